adc_sample_scheduler: RTL

Paces the successive-approximation ADC at a programmable sample rate. It issues conversion-start pulses, tracks each conversion to completion or timeout, and buffers results in a small FIFO. The FIFO drains through a valid/ready handshake toward the DAC shift-out path. It sits between the ADC core and the shift-out block in the top level, and lets sample rate and back-pressure be controlled independently of ADC conversion time.

---
 rtl/adc_sched_pkg.sv | 21 ++
 rtl/adc_sample_scheduler_fifo.sv | 44 ++++
 rtl/adc_sample_scheduler.sv | 120 ++++++++++++
 3 files changed

// File: rtl/adc_sched_pkg.sv
// Shared types and default widths for the ADC sample scheduler.
package adc_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    CONV
  } sched_state_t;

  localparam int unsigned ADC_DATA_W      = 14;
  localparam int unsigned ADC_OUT_W       = 16;
  localparam int unsigned ADC_DIV_W       = 16;
  localparam int unsigned TIMEOUT_CYC_DEF = 256;

  function automatic int unsigned timeout_w(input int unsigned cyc);
    return (cyc < 2) ? 1 : $clog2(cyc);
  endfunction

  localparam int unsigned TIMEOUT_W = timeout_w(TIMEOUT_CYC_DEF);

endpackage

// File: rtl/adc_sample_scheduler_fifo.sv
// Synchronous result FIFO; pointers carry an extra wrap bit to tell full from empty.
module sample_fifo #(
  parameter int unsigned WIDTH = 14,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head    = mem[rd_ptr[AW-1:0]];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/adc_sample_scheduler.sv
// Paces ADC conversions at a programmable rate, tracks completion/timeout and
// queues results for a valid/ready consumer.
module adc_sample_scheduler
  import adc_sched_pkg::*;
#(
  parameter int unsigned DATA_W      = ADC_DATA_W,
  parameter int unsigned OUT_W       = ADC_OUT_W,
  parameter int unsigned DIV_W       = ADC_DIV_W,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              enable_i,
  input  logic [DIV_W-1:0]  period_i,
  input  logic              clear_i,
  output logic              adc_start_o,
  input  logic [DATA_W-1:0] adc_data_i,
  input  logic              adc_rdy_i,
  output logic [OUT_W-1:0]  out_data_o,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              missed_o,
  output logic              overrun_o,
  output logic              timeout_o
);

  localparam int unsigned TO_W = timeout_w(TIMEOUT_CYC);

  sched_state_t      state;
  logic [DIV_W-1:0]  count;
  logic [DIV_W-1:0]  period_q;
  logic [DIV_W-1:0]  period_eff;
  logic [TO_W-1:0]   to_cnt;
  logic              tick;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  assign period_eff  = (period_i < DIV_W'(2)) ? DIV_W'(2) : period_i;
  assign tick        = enable_i && (count == period_q - DIV_W'(1));
  assign out_valid_o = !fifo_empty;
  assign fifo_pop    = out_valid_o && out_ready_i;
  assign fifo_push   = (state == CONV) && adc_rdy_i && (!fifo_full || fifo_pop);
  assign out_data_o  = fifo_empty ? '0 : OUT_W'(fifo_head);

  // Period is re-latched while idle so the first interval after enable uses it.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      count    <= '0;
      period_q <= DIV_W'(2);
    end else if (!enable_i || tick) begin
      count    <= '0;
      period_q <= period_eff;
    end else begin
      count    <= count + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state       <= IDLE;
      adc_start_o <= 1'b0;
      to_cnt      <= '0;
      missed_o    <= 1'b0;
      overrun_o   <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      adc_start_o <= 1'b0;
      // Clear first so a same-cycle set below takes precedence.
      if (clear_i) begin
        missed_o  <= 1'b0;
        overrun_o <= 1'b0;
        timeout_o <= 1'b0;
      end
      if (tick && state != IDLE) missed_o <= 1'b1;
      case (state)
        IDLE: begin
          if (tick) begin
            state       <= START;
            adc_start_o <= 1'b1;
          end
        end
        START: begin
          to_cnt <= '0;
          state  <= CONV;
        end
        CONV: begin
          if (adc_rdy_i) begin
            if (fifo_full && !fifo_pop) overrun_o <= 1'b1;
            state <= IDLE;
          end else if (to_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
            timeout_o <= 1'b1;
            state     <= IDLE;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sample_fifo #(
    .WIDTH(DATA_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk_i),
    .rst  (reset_i),
    .push (fifo_push),
    .pop  (fifo_pop),
    .din  (adc_data_i),
    .full (fifo_full),
    .empty(fifo_empty),
    .head (fifo_head)
  );

endmodule
